// File: rtl/ret_addr_stack_pkg.sv
// Shared core constants and the checkpoint record type for the return address stack.
package ret_addr_stack_pkg;
    localparam int XLEN            = 32;
    localparam int RAS_DEPTH_DEF   = 8;
    localparam int INSTR_BYTES_DEF = 4;
    localparam int RAS_PTR_MAX_W   = 8;

    // Sized for the largest supported stack; narrower stacks zero-extend into it.
    typedef struct packed {
        logic [RAS_PTR_MAX_W-1:0] ptr;
        logic [RAS_PTR_MAX_W:0]   cnt;
        logic [XLEN-1:0]          top;
    } ras_ckpt_t;
endpackage

// File: rtl/ret_addr_stack.sv
// Circular return address stack for fetch: push link on call, predict and pop on return.
// Optional checkpoint/restore of the stack pointer and top entry under RAS_CKPT_EN.
module ret_addr_stack
    import ret_addr_stack_pkg::*;
#(
    parameter int DEPTH       = RAS_DEPTH_DEF,
    parameter int AW          = XLEN,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          instr_vld_i,
    input  logic          call_i,
    input  logic          return_i,
    input  logic [AW-1:0] pc_i,
    input  logic          flush_i,
`ifdef RAS_CKPT_EN
    input  logic          ckpt_i,
    input  logic          restore_i,
`endif
    output logic          pred_vld_o,
    output logic [AW-1:0] pred_target_o,
    output logic          empty_o,
    output logic          full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_tos_ptr;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [AW-1:0] w_link;
    logic [PW-1:0] w_tos_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    logic [AW-1:0] w_wr_data;

    assign w_push     = instr_vld_i & call_i;
    assign w_pop      = instr_vld_i & return_i;
    assign w_nonempty = (r_count != '0);
    assign w_link     = pc_i + AW'(INSTR_BYTES);

    // Prediction always reflects the state before this cycle's update.
    assign pred_target_o = r_mem[r_tos_ptr];
    assign pred_vld_o    = w_pop & w_nonempty;
    assign empty_o       = ~w_nonempty;
    assign full_o        = (r_count == CW'(DEPTH));

`ifdef RAS_CKPT_EN
    ras_ckpt_t     r_shadow;
    logic [AW-1:0] w_top_next;
`endif

    always_comb begin
        w_tos_next = r_tos_ptr;
        w_cnt_next = r_count;
        w_wr_en    = 1'b0;
        w_wr_idx   = r_tos_ptr;
        w_wr_data  = w_link;
`ifdef RAS_CKPT_EN
        if (restore_i) begin
            w_tos_next = PW'(r_shadow.ptr);
            w_cnt_next = CW'(r_shadow.cnt);
            w_wr_en    = 1'b1;
            w_wr_idx   = PW'(r_shadow.ptr);
            w_wr_data  = AW'(r_shadow.top);
        end else
`endif
        if (flush_i) begin
            w_tos_next = '0;
            w_cnt_next = '0;
        end else if (w_push && w_pop) begin
            // Coroutine jump: replace the top in place.
            w_wr_en = 1'b1;
            if (!w_nonempty) w_cnt_next = CW'(1);
        end else if (w_push) begin
            w_tos_next = r_tos_ptr + PW'(1);
            w_wr_en    = 1'b1;
            w_wr_idx   = r_tos_ptr + PW'(1);
            if (!full_o) w_cnt_next = r_count + CW'(1);
        end else if (w_pop && w_nonempty) begin
            w_tos_next = r_tos_ptr - PW'(1);
            w_cnt_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tos_ptr <= '0;
            r_count   <= '0;
        end else begin
            r_tos_ptr <= w_tos_next;
            r_count   <= w_cnt_next;
        end
    end

    // Entry storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
    end

`ifdef RAS_CKPT_EN
    assign w_top_next = (w_wr_en && (w_wr_idx == w_tos_next)) ? w_wr_data : r_mem[w_tos_next];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if (ckpt_i && !restore_i) begin
            r_shadow.ptr <= RAS_PTR_MAX_W'(w_tos_next);
            r_shadow.cnt <= (RAS_PTR_MAX_W + 1)'(w_cnt_next);
            r_shadow.top <= XLEN'(w_top_next);
        end
    end
`endif
endmodule

// File: tb/tb_ret_addr_stack.sv
// Randomized and directed bench for ret_addr_stack (DEPTH=4) against a queue-based stack model.
module tb_ret_addr_stack;
    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          instr_vld_i = 1'b0;
    logic          call_i = 1'b0;
    logic          return_i = 1'b0;
    logic [AW-1:0] pc_i = '0;
    logic          flush_i = 1'b0;
    logic          ckpt_i = 1'b0;
    logic          restore_i = 1'b0;
    logic          pred_vld_o;
    logic [AW-1:0] pred_target_o;
    logic          empty_o;
    logic          full_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the stack as a queue, newest at the back; shadow is a copied stack.
    logic [AW-1:0] mq [$];
    logic [AW-1:0] sq [$];

    always #5 clk = ~clk;

    ret_addr_stack #(.DEPTH(DEPTH), .AW(AW), .INSTR_BYTES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .instr_vld_i  (instr_vld_i),
        .call_i       (call_i),
        .return_i     (return_i),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
`ifdef RAS_CKPT_EN
        .ckpt_i       (ckpt_i),
        .restore_i    (restore_i),
`endif
        .pred_vld_o   (pred_vld_o),
        .pred_target_o(pred_target_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction: drive at negedge, check outputs against model, update model at posedge.
    // exp_v >= 0 adds a hand-computed check of the prediction on top of the model.
    task automatic cycle(input logic rst, input logic vld, input logic cl, input logic rt,
                         input logic [AW-1:0] pc, input logic fl, input logic ck, input logic rs,
                         input int exp_v, input logic [AW-1:0] exp_t);
        logic          m_pv;
        logic          push;
        logic          pop;
        logic [AW-1:0] link;
        @(negedge clk);
        rst_i = rst; instr_vld_i = vld; call_i = cl; return_i = rt;
        pc_i = pc; flush_i = fl; ckpt_i = ck; restore_i = rs;
        #1;
        push = vld & cl;
        pop  = vld & rt;
        link = pc + 32'd4;
        m_pv = pop && (mq.size() != 0);
        check_val("pred_vld", {31'b0, pred_vld_o}, {31'b0, m_pv});
        if (m_pv) check_val("pred_target", pred_target_o, mq[mq.size()-1]);
        check_val("empty", {31'b0, empty_o}, {31'b0, mq.size() == 0});
        check_val("full", {31'b0, full_o}, {31'b0, mq.size() == DEPTH});
        if (exp_v >= 0) begin
            check_val("dir_pred_vld", {31'b0, pred_vld_o}, exp_v[31:0]);
            if (exp_v == 1) check_val("dir_pred_target", pred_target_o, exp_t);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            sq.delete();
        end else begin
            if (rs) mq = sq;
            else if (fl) mq.delete();
            else if (push && pop) begin
                if (mq.size() == 0) mq.push_back(link);
                else mq[mq.size()-1] = link;
            end else if (push) begin
                mq.push_back(link);
                if (mq.size() > DEPTH) void'(mq.pop_front());
            end else if (pop && mq.size() != 0) begin
                void'(mq.pop_back());
            end
            if (ck && !rs) sq = mq;
        end
        #1;
        rst_i = 1'b0; instr_vld_i = 1'b0; call_i = 1'b0; return_i = 1'b0;
        flush_i = 1'b0; ckpt_i = 1'b0; restore_i = 1'b0;
        $display("[TB] rst=%0b vld=%0b call=%0b ret=%0b pc=0x%0h flush=%0b ckpt=%0b rest=%0b depth=%0d",
                 rst, vld, cl, rt, pc, fl, ck, rs, mq.size());
    endtask

    task automatic chk_state(input logic e, input logic f);
        @(negedge clk);
        #1;
        check_val("state_empty", {31'b0, empty_o}, {31'b0, e});
        check_val("state_full", {31'b0, full_o}, {31'b0, f});
    endtask

    task automatic call(input logic [AW-1:0] pc);
        cycle(0, 1, 1, 0, pc, 0, 0, 0, -1, '0);
    endtask

    task automatic ret(input int ev, input logic [AW-1:0] et);
        cycle(0, 1, 0, 1, 32'h0, 0, 0, 0, ev, et);
    endtask

    initial begin
        cycle(1, 0, 0, 0, '0, 0, 0, 0, -1, '0);
        cycle(1, 0, 0, 0, '0, 0, 0, 0, -1, '0);
        chk_state(1, 0);
        cycle(0, 1, 0, 1, 32'h100, 0, 0, 0, 0, '0);
        chk_state(1, 0);

        call(32'h1000);
        call(32'h2000);
        ret(1, 32'h2004);
        ret(1, 32'h1004);
        ret(0, '0);

        for (int i = 1; i <= 6; i++) begin
            call(32'h10 * i);
            if (i == 4) chk_state(0, 1);
        end
        ret(1, 32'h64);
        ret(1, 32'h54);
        ret(1, 32'h44);
        ret(1, 32'h34);
        ret(0, '0);

        call(32'h500);
        cycle(0, 1, 1, 1, 32'h800, 0, 0, 0, 1, 32'h504);
        ret(1, 32'h804);
        chk_state(1, 0);

        call(32'h3000);
        call(32'h4000);
        cycle(0, 1, 1, 0, 32'h5000, 1, 0, 0, -1, '0);
        chk_state(1, 0);
        ret(0, '0);

        // Random traffic; flushes and resets kept rare so the stack fills and wraps.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 24) == 0, 0, 0, -1, '0);
        end

`ifdef RAS_CKPT_EN
        cycle(0, 0, 0, 0, '0, 1, 0, 0, -1, '0);
        call(32'hA00);
        cycle(0, 0, 0, 0, '0, 0, 1, 0, -1, '0);
        ret(1, 32'hA04);
        call(32'hB00);
        cycle(0, 0, 0, 0, '0, 0, 0, 1, -1, '0);
        ret(1, 32'hA04);
        chk_state(1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
